// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone multi-master arbiter: state encoding,
// cycle-type identifiers and index-width helpers.
package wb_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // A single master still needs a 1-bit index so owner registers are never zero-width.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/wb_multi_arbiter_if.sv
// Bundle of the packed master-side and single slave-side Wishbone signals.
interface wb_multi_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2
);
  logic [32*NUM_MASTERS-1:0] wbm_adr_i;
  logic [32*NUM_MASTERS-1:0] wbm_dat_i;
  logic [4*NUM_MASTERS-1:0]  wbm_sel_i;
  logic [3*NUM_MASTERS-1:0]  wbm_cti_i;
  logic [2*NUM_MASTERS-1:0]  wbm_bte_i;
  logic [NUM_MASTERS-1:0]    wbm_we_i;
  logic [NUM_MASTERS-1:0]    wbm_cyc_i;
  logic [NUM_MASTERS-1:0]    wbm_stb_i;
  logic [32*NUM_MASTERS-1:0] wbm_dat_o;
  logic [NUM_MASTERS-1:0]    wbm_ack_o;
  logic [NUM_MASTERS-1:0]    wbm_err_o;
  logic [NUM_MASTERS-1:0]    wbm_rty_o;

  logic [31:0] wbs_adr_o;
  logic [31:0] wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o;
  logic        wbs_cyc_o;
  logic        wbs_stb_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_i;
  logic        wbs_err_i;
  logic        wbs_rty_i;

  // Arbiter view: slave to the masters, master to the downstream slave.
  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_cti_i, wbm_bte_i,
    input  wbm_we_i, wbm_cyc_i, wbm_stb_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    output wbs_cti_o, wbs_bte_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_cti_i, wbm_bte_i,
    output wbm_we_i, wbm_cyc_i, wbm_stb_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    input  wbs_cti_o, wbs_bte_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );
endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       last_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = IDX_W'((32'(last_i) + i) % NUM_MASTERS);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_multi_arbiter.sv
// Round-robin Wishbone arbiter: N masters onto one slave, non-preemptive
// ownership held for the whole cyc, with a stalled-strobe watchdog abort.
module wb_multi_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_WIDTH       = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_multi_arbiter_if.slave      bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);

  localparam int unsigned IDX_W = idx_width(NUM_MASTERS);

  logic [0:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [TO_WIDTH-1:0]    wd_q, wd_d;

  logic                   owned, own_cyc, own_stb, term, abort;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  wb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req_i   (bus.wbm_cyc_i),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign owned   = (state_q == ST_OWNED);
  assign own_cyc = owned & bus.wbm_cyc_i[idx_q];
  assign own_stb = owned & bus.wbm_stb_i[idx_q];
  assign term    = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;

  // A real termination on the terminal count beats the watchdog.
  assign abort = (TIMEOUT_CYCLES != 0) && own_cyc && own_stb && !term &&
                 (wd_q == TO_WIDTH'(TIMEOUT_CYCLES));

  always_comb begin
    bus.wbs_adr_o = '0;
    bus.wbs_dat_o = '0;
    bus.wbs_sel_o = '0;
    bus.wbs_we_o  = 1'b0;
    bus.wbs_cti_o = '0;
    bus.wbs_bte_o = '0;
    if (owned) begin
      bus.wbs_adr_o = bus.wbm_adr_i[32*idx_q +: 32];
      bus.wbs_dat_o = bus.wbm_dat_i[32*idx_q +: 32];
      bus.wbs_sel_o = bus.wbm_sel_i[4*idx_q +: 4];
      bus.wbs_we_o  = bus.wbm_we_i[idx_q];
      bus.wbs_cti_o = bus.wbm_cti_i[3*idx_q +: 3];
      bus.wbs_bte_o = bus.wbm_bte_i[2*idx_q +: 2];
    end
  end

  assign bus.wbs_cyc_o = own_cyc & ~abort;
  assign bus.wbs_stb_o = own_stb & ~abort;

  assign bus.wbm_dat_o = {NUM_MASTERS{bus.wbs_dat_i}};
  assign bus.wbm_ack_o = grant_q & {NUM_MASTERS{owned & bus.wbs_ack_i}};
  assign bus.wbm_err_o = grant_q & {NUM_MASTERS{owned & (bus.wbs_err_i | abort)}};
  assign bus.wbm_rty_o = grant_q & {NUM_MASTERS{owned & bus.wbs_rty_i}};

  assign grant_o   = grant_q;
  assign timeout_o = abort;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWNED;
          grant_d = pick_gnt;
          idx_d   = pick_idx;
        end
      end
      default: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = idx_q;
        end
      end
    endcase
  end

  always_comb begin
    wd_d = wd_q;
    if (!own_cyc || term || abort) begin
      wd_d = '0;
    end else if (own_stb && (wd_q != '1)) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_wb_multi_arbiter.sv
// Randomised scoreboard bench for wb_multi_arbiter (4 masters, 8-cycle watchdog).
module tb_wb_multi_arbiter;
  import wb_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int          T  = 8;
  localparam int unsigned TW = 4;

  typedef struct {
    logic [N-1:0] grant, ack, err, rty;
    logic         tmo, cyc, stb;
    logic [73:0]  req;
    logic [31:0]  dat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] grant;
  logic         tmo;

  always #5 clk = ~clk;

  wb_multi_arbiter_if #(.NUM_MASTERS(N)) bus ();

  wb_multi_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (T),
    .TO_WIDTH       (TW)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus),
    .grant_o   (grant),
    .timeout_o (tmo)
  );

  exp_t expq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   stim_done = 1'b0;

  // Reference model state: owner (-1 = free), previous owner, stalled-cycle count,
  // and the number of beats each master still wants to complete.
  int own, last, wd;
  int rem [N];
  int n_tmo_seen = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step(input int p_new, input bit stall, input bit do_rst);
    exp_t           e;
    logic [32*N-1:0] adr_v, dat_v;
    logic [4*N-1:0]  sel_v;
    logic [3*N-1:0]  cti_v;
    logic [2*N-1:0]  bte_v;
    logic [N-1:0]    we_v, cyc, stb, onehot;
    bit              ack, err, rty, term, abort;
    int              r;

    @(posedge clk);
    #1;
    rst = do_rst;
    for (int k = 0; k < N; k++) begin
      cyc[k]           = rem[k] > 0;
      stb[k]           = cyc[k] && (($urandom % 8) != 0);
      adr_v[32*k +: 32] = $urandom;
      dat_v[32*k +: 32] = $urandom;
      sel_v[4*k +: 4]   = 4'($urandom);
      bte_v[2*k +: 2]   = 2'($urandom);
      we_v[k]           = 1'($urandom);
      cti_v[3*k +: 3]   = (rem[k] == 1) ? CTI_EOB : CTI_INCR;
    end
    bus.wbm_adr_i = adr_v;
    bus.wbm_dat_i = dat_v;
    bus.wbm_sel_i = sel_v;
    bus.wbm_cti_i = cti_v;
    bus.wbm_bte_i = bte_v;
    bus.wbm_we_i  = we_v;
    bus.wbm_cyc_i = cyc;
    bus.wbm_stb_i = stb;

    ack = 1'b0; err = 1'b0; rty = 1'b0;
    if (own >= 0 && stb[own]) begin
      if (stall) begin
        ack = (wd == T) && (($urandom % 2) == 1);
      end else begin
        r = int'($urandom % 16);
        if (r == 0) err = 1'b1;
        else if (r == 1) rty = 1'b1;
        else ack = ($urandom % 2) == 1;
      end
    end else begin
      ack = ($urandom % 16) == 0;
    end
    bus.wbs_ack_i = ack;
    bus.wbs_err_i = err;
    bus.wbs_rty_i = rty;
    bus.wbs_dat_i = $urandom;

    term   = ack || err || rty;
    abort  = (own >= 0) && cyc[own] && stb[own] && (wd == T) && !term;
    onehot = '0;
    if (own >= 0) onehot[own] = 1'b1;
    if (abort) n_tmo_seen++;

    e.grant = onehot;
    e.ack   = ack ? onehot : '0;
    e.err   = (err || abort) ? onehot : '0;
    e.rty   = rty ? onehot : '0;
    e.tmo   = abort;
    e.cyc   = (own >= 0) && cyc[own] && !abort;
    e.stb   = (own >= 0) && stb[own] && !abort;
    e.req   = '0;
    if (own >= 0)
      e.req = {adr_v[32*own +: 32], dat_v[32*own +: 32], sel_v[4*own +: 4],
               we_v[own], cti_v[3*own +: 3], bte_v[2*own +: 2]};
    e.dat   = bus.wbs_dat_i;
    expq.push_back(e);

    if (own >= 0 && stb[own] && (term || abort) && rem[own] > 0) rem[own]--;

    if (do_rst) begin
      own = -1; last = N - 1; wd = 0;
      for (int k = 0; k < N; k++) rem[k] = 0;
    end else if (own < 0) begin
      wd = 0;
      for (int i = 1; i <= N; i++)
        if (own < 0 && cyc[(last + i) % N]) own = (last + i) % N;
    end else if (!cyc[own]) begin
      last = own; own = -1; wd = 0;
    end else if (term || abort) begin
      wd = 0;
    end else if (stb[own] && wd < (1 << TW) - 1) begin
      wd++;
    end

    if (!do_rst)
      for (int k = 0; k < N; k++)
        if (!cyc[k] && rem[k] == 0 && int'($urandom % 100) < p_new)
          rem[k] = 1 + int'($urandom % 4);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("grant",   128'(grant),              128'(e.grant));
        chk("ack",     128'(bus.wbm_ack_o),      128'(e.ack));
        chk("err",     128'(bus.wbm_err_o),      128'(e.err));
        chk("rty",     128'(bus.wbm_rty_o),      128'(e.rty));
        chk("timeout", 128'(tmo),                128'(e.tmo));
        chk("wbs_cyc", 128'(bus.wbs_cyc_o),      128'(e.cyc));
        chk("wbs_stb", 128'(bus.wbs_stb_o),      128'(e.stb));
        chk("wbs_req", 128'({bus.wbs_adr_o, bus.wbs_dat_o, bus.wbs_sel_o, bus.wbs_we_o,
                             bus.wbs_cti_o, bus.wbs_bte_o}), 128'(e.req));
        chk("wbm_dat", 128'(bus.wbm_dat_o),      {N{e.dat}});
      end
    end
  end

  initial begin : stimulus
    bit stall;
    rst = 1'b1;
    bus.wbm_adr_i = '0; bus.wbm_dat_i = '0; bus.wbm_sel_i = '0;
    bus.wbm_cti_i = '0; bus.wbm_bte_i = '0; bus.wbm_we_i  = '0;
    bus.wbm_cyc_i = '0; bus.wbm_stb_i = '0;
    bus.wbs_dat_i = '0; bus.wbs_ack_i = 1'b0; bus.wbs_err_i = 1'b0; bus.wbs_rty_i = 1'b0;
    own = -1; last = N - 1; wd = 0;
    for (int k = 0; k < N; k++) rem[k] = 0;
    repeat (2) @(posedge clk);

    // Masters 0 and 1 request together right after reset, nobody else.
    rem[0] = 1; rem[1] = 1;
    repeat (20) step(0, 1'b0, 1'b0);

    // All four masters request continuously: rotation 0,1,2,3,0...
    for (int k = 0; k < N; k++) rem[k] = 2;
    repeat (60) step(100, 1'b0, 1'b0);

    // Silent slave: watchdog aborts and ack on the terminal cycle.
    repeat (300) step(60, 1'b1, 1'b0);

    // Reset in the middle of an owned burst.
    rem[2] = 4;
    repeat (6) step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1);
    rem[0] = 2; rem[3] = 2;
    repeat (12) step(0, 1'b0, 1'b0);

    stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 250) == 0) stall = ($urandom % 3) == 0;
      step(30, stall, ($urandom % 300) == 0);
    end

    repeat (3) @(posedge clk);
    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    budget = 0;
    while (!stim_done && budget < 20000) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    chk("stim_done", 128'(stim_done), 128'(1));
    chk("drain",     128'(expq.size()), 128'(0));
    if (n_tmo_seen == 0) $display("note: no watchdog abort was exercised");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_multi_arbiter.md
WB_MULTI_ARBITER -- requirements
Module: wb_multi_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of Wishbone masters (1..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, stalled-cycle limit before error abort (0 = watchdog disabled).
REQ-003 Parameter TO_WIDTH, default 8, watchdog counter width (2**TO_WIDTH-1 >= TIMEOUT_CYCLES).
REQ-004 wb_clk_i  in  1  sole clock, all logic rising-edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 wbm_adr_i/wbm_dat_i  in  32*NUM_MASTERS each  packed master address/write data, master k at [32k+31:32k].
REQ-007 wbm_sel_i  in  4*NUM_MASTERS; wbm_cti_i  in  3*NUM_MASTERS; wbm_bte_i  in  2*NUM_MASTERS; packed per master.
REQ-008 wbm_we_i/wbm_cyc_i/wbm_stb_i  in  NUM_MASTERS each  per-master control.
REQ-009 wbm_dat_o  out  32*NUM_MASTERS  read data, slave data broadcast to every slot.
REQ-010 wbm_ack_o/wbm_err_o/wbm_rty_o  out  NUM_MASTERS each  per-master termination.
REQ-011 wbs_adr_o 32, wbs_dat_o 32, wbs_sel_o 4, wbs_we_o 1, wbs_cyc_o 1, wbs_stb_o 1, wbs_cti_o 3, wbs_bte_o 2  out  slave-side request.
REQ-012 wbs_dat_i 32, wbs_ack_i 1, wbs_err_i 1, wbs_rty_i 1  in  slave-side response.
REQ-013 grant_o  out  NUM_MASTERS  registered one-hot owner, all-zero when bus free.
REQ-014 timeout_o  out  1  one-cycle pulse when watchdog aborts a transfer.

Function
REQ-015 Two states: IDLE (no owner), OWNED (grant_o one-hot).
REQ-016 IDLE: if any wbm_cyc_i set, grant registered next edge to first requester searching from (last_owner+1) mod NUM_MASTERS upward, wrapping; state -> OWNED.
REQ-017 OWNED: owner retained while its wbm_cyc_i stays high, including across cti=010 bursts and between stb pulses; no preemption.
REQ-018 OWNED: owner wbm_cyc_i low -> state IDLE next edge, grant_o cleared, last_owner updated; re-arbitration occurs in IDLE (minimum one free cycle between owners).
REQ-019 Slave request outputs combinationally muxed from owner; wbs_cyc_o/wbs_stb_o = owner cyc/stb AND OWNED AND NOT abort; all zero in IDLE.
REQ-020 wbm_ack_o/err_o/rty_o[k] = corresponding slave signal only for owner k; zero for all other masters and in IDLE.
REQ-021 Watchdog counts cycles with owner stb high and no slave ack/err/rty; clears on any termination or owner change.
REQ-022 Counter reaching TIMEOUT_CYCLES: abort cycle asserts wbm_err_o[owner]=1, timeout_o=1, wbs_cyc_o=wbs_stb_o=0, counter cleared; ownership kept until owner drops cyc.
REQ-023 Slave ack coincident with timeout terminal count: ack wins, no abort.
REQ-024 NUM_MASTERS=1: grant granted to master 0 whenever cyc high, same latency rules.
REQ-025 Throughput: no added latency on response path; request path adds only the single arbitration cycle at grant.

Reset
REQ-026 On wb_rst_i: state IDLE, grant_o=0, last_owner=NUM_MASTERS-1 (master 0 wins first), watchdog=0, timeout_o=0.
REQ-027 Reset mid-transfer: all wbs_* control and wbm_ack/err/rty outputs zero the cycle after reset sampled; no response forwarded.

Structure
REQ-028 Package wb_arb_pkg holds state encoding, CTI constants (CLASSIC 000, INCR 010, EOB 111), and clog2 helper.
REQ-029 One sub-module wb_rr_pick: combinational round-robin picker (request vector, last_owner -> one-hot grant, valid).

Verification
REQ-030 Reset, then cyc on masters 0 and 1 same cycle -> grant_o=01 one cycle later; master 0 drops cyc -> IDLE, then grant_o=10.
REQ-031 Master 1 holds cyc through 4-beat cti=010 burst ending 111 while master 0 requests -> four acks only to master 1, grant unchanged until master 1 drops cyc.
REQ-032 N=4, masters 0-3 continuously requesting -> grant order 0,1,2,3,0 with one IDLE cycle between each.
REQ-033 TIMEOUT_CYCLES=8, slave never acks -> wbm_err_o[owner] and timeout_o high exactly 8 cycles after stb, wbs_stb_o low that cycle.
REQ-034 Slave ack on terminal watchdog cycle -> ack delivered, timeout_o stays 0.
REQ-035 wb_rst_i asserted during burst -> next cycle wbs_cyc_o=0, grant_o=0; first post-reset grant to master 0.
